// File: rtl/spi_slave_if.sv
// Byte-level user bus between spi_slave and the FPGA fabric.
// The slave modport is the SPI responder side; the master modport is the user logic side.
interface spi_slave_if;
    logic       RX_DV;
    logic [7:0] RX_Byte;
    logic       TX_DV;
    logic [7:0] TX_Byte;
    logic       TX_Ready;
    logic       Overrun;

    modport slave (
        output RX_DV, RX_Byte, TX_Ready, Overrun,
        input  TX_DV, TX_Byte
    );

    modport master (
        input  RX_DV, RX_Byte, TX_Ready, Overrun,
        output TX_DV, TX_Byte
    );
endinterface

// File: rtl/spi_slave.sv
// SPI responder oversampled on i_Clk: MSB-first byte receive with one-cycle valid pulse,
// and a one-deep holding register feeding the MISO shift register.
module spi_slave #(
    parameter int unsigned SPI_MODE    = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    spi_slave_if.slave io_bus,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);
    localparam bit CPOL        = ((SPI_MODE / 2) % 2) == 1;
    localparam bit CPHA        = (SPI_MODE % 2) == 1;
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic {StIdle, StActive} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_clk_prev;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_rx_shift;
    logic [7:0]             r_rx_byte;
    logic                   r_rx_dv;
    logic [7:0]             r_tx_shift;
    logic [7:0]             r_hold;
    logic                   r_tx_ready;
    logic                   r_overrun;
    logic                   r_miso;
    logic                   r_miso_en;

    logic       w_sclk;
    logic       w_cs_n;
    logic       w_mosi;
    logic       w_rise;
    logic       w_fall;
    logic       w_sample;
    logic       w_drive;
    logic       w_load;
    logic       w_tx_wr;
    logic [7:0] w_load_byte;

    always_comb begin
        w_sclk      = r_clk_sync[SYNC_STAGES-1];
        w_cs_n      = r_cs_sync[SYNC_STAGES-1];
        w_mosi      = r_mosi_sync[SYNC_STAGES-1];
        w_rise      = w_sclk & ~r_clk_prev;
        w_fall      = ~w_sclk & r_clk_prev;
        w_sample    = SAMPLE_RISE ? w_rise : w_fall;
        w_drive     = SAMPLE_RISE ? w_fall : w_rise;
        w_load      = ~w_cs_n & ((r_state == StIdle) |
                                 ((r_state == StActive) & w_sample & (r_bit_cnt == 3'd7)));
        w_tx_wr     = io_bus.TX_DV & r_tx_ready;
        w_load_byte = r_tx_ready ? DEFAULT_TX : r_hold;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state     <= StIdle;
            r_clk_sync  <= {SYNC_STAGES{CPOL}};
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= '0;
            r_clk_prev  <= CPOL;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_rx_byte   <= 8'h00;
            r_rx_dv     <= 1'b0;
            r_tx_shift  <= 8'h00;
            r_hold      <= 8'h00;
            r_tx_ready  <= 1'b1;
            r_overrun   <= 1'b0;
            r_miso      <= 1'b1;
            r_miso_en   <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            r_clk_prev  <= w_sclk;
            r_rx_dv     <= 1'b0;

            // A load reads the holding register before this cycle's write lands.
            if (w_tx_wr) begin
                r_hold     <= io_bus.TX_Byte;
                r_tx_ready <= 1'b0;
            end else if (w_load && !r_tx_ready) begin
                r_tx_ready <= 1'b1;
            end
            if (io_bus.TX_DV && !r_tx_ready) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (!w_cs_n) begin
                        r_state   <= StActive;
                        r_miso_en <= 1'b1;
                        r_bit_cnt <= 3'd0;
                    end
                end
                StActive: begin
                    if (w_cs_n) begin
                        r_state    <= StIdle;
                        r_miso_en  <= 1'b0;
                        r_miso     <= 1'b1;
                        r_bit_cnt  <= 3'd0;
                        r_rx_shift <= 8'h00;
                    end else if (w_sample) begin
                        r_rx_shift <= {r_rx_shift[6:0], w_mosi};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_byte <= {r_rx_shift[6:0], w_mosi};
                            r_rx_dv   <= 1'b1;
                        end
                    end else if (w_drive && (CPHA || r_bit_cnt != 3'd0)) begin
                        // CPHA=0 already shows the MSB at load, so skip the drive edge after it.
                        r_miso     <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end
                default: r_state <= StIdle;
            endcase

            if (w_load) begin
                if (CPHA) begin
                    r_tx_shift <= w_load_byte;
                end else begin
                    r_miso     <= w_load_byte[7];
                    r_tx_shift <= {w_load_byte[6:0], 1'b0};
                end
            end
        end
    end

    assign io_bus.RX_DV    = r_rx_dv;
    assign io_bus.RX_Byte  = r_rx_byte;
    assign io_bus.TX_Ready = r_tx_ready;
    assign io_bus.Overrun  = r_overrun;
    assign o_SPI_MISO      = r_miso;
    assign o_SPI_MISO_En   = r_miso_en;
endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: three instances (modes 3, 0, 1) driven by a bit-banged master.
module tb_spi_slave;
    logic       clk;
    logic       rst;
    logic [2:0] spi_clk;
    logic [2:0] cs_n;
    logic [2:0] mosi;
    wire  [2:0] miso;
    wire  [2:0] miso_en;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    spi_slave_if u_if0 ();
    spi_slave_if u_if1 ();
    spi_slave_if u_if2 ();

    spi_slave #(.SPI_MODE(3), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) u_dut0 (
        .i_Clk(clk), .i_Rst(rst), .io_bus(u_if0.slave),
        .i_SPI_Clk(spi_clk[0]), .i_SPI_CS_n(cs_n[0]), .i_SPI_MOSI(mosi[0]),
        .o_SPI_MISO(miso[0]), .o_SPI_MISO_En(miso_en[0])
    );
    spi_slave #(.SPI_MODE(0), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) u_dut1 (
        .i_Clk(clk), .i_Rst(rst), .io_bus(u_if1.slave),
        .i_SPI_Clk(spi_clk[1]), .i_SPI_CS_n(cs_n[1]), .i_SPI_MOSI(mosi[1]),
        .o_SPI_MISO(miso[1]), .o_SPI_MISO_En(miso_en[1])
    );
    spi_slave #(.SPI_MODE(1), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) u_dut2 (
        .i_Clk(clk), .i_Rst(rst), .io_bus(u_if2.slave),
        .i_SPI_Clk(spi_clk[2]), .i_SPI_CS_n(cs_n[2]), .i_SPI_MOSI(mosi[2]),
        .o_SPI_MISO(miso[2]), .o_SPI_MISO_En(miso_en[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (u_if0.RX_DV === 1'b1) begin
            if (q0.size() == 0) check("rx0_unexpected_pulse", 32'd1, 32'd0);
            else check("rx0_byte", {24'd0, u_if0.RX_Byte}, {24'd0, q0.pop_front()});
        end
    end
    always @(negedge clk) begin
        if (u_if1.RX_DV === 1'b1) begin
            if (q1.size() == 0) check("rx1_unexpected_pulse", 32'd1, 32'd0);
            else check("rx1_byte", {24'd0, u_if1.RX_Byte}, {24'd0, q1.pop_front()});
        end
    end
    always @(negedge clk) begin
        if (u_if2.RX_DV === 1'b1) begin
            if (q2.size() == 0) check("rx2_unexpected_pulse", 32'd1, 32'd0);
            else check("rx2_byte", {24'd0, u_if2.RX_Byte}, {24'd0, q2.pop_front()});
        end
    end

    function automatic int mode_of(input int k);
        case (k)
            0:       return 3;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_begin(input int k);
        cs_n[k] = 1'b0;
        half();
    endtask

    task automatic spi_end(input int k);
        half();
        cs_n[k] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input int k, input logic [7:0] tx, input int n,
                            output logic [7:0] rx);
        logic cpol;
        logic cpha;
        cpol = (mode_of(k) / 2) == 1;
        cpha = (mode_of(k) % 2) == 1;
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            if (!cpha) begin
                mosi[k] = tx[i];
                half();
                spi_clk[k] = ~cpol;
                rx[i] = miso[k];
                half();
                spi_clk[k] = cpol;
            end else begin
                spi_clk[k] = ~cpol;
                mosi[k] = tx[i];
                half();
                spi_clk[k] = cpol;
                rx[i] = miso[k];
                half();
            end
        end
    endtask

    task automatic xfer_byte(input int k, input logic [7:0] tx, input logic [7:0] exp_miso,
                             input string name);
        logic [7:0] rx;
        case (k)
            0:       q0.push_back(tx);
            1:       q1.push_back(tx);
            default: q2.push_back(tx);
        endcase
        spi_bits(k, tx, 8, rx);
        check(name, {24'd0, rx}, {24'd0, exp_miso});
    endtask

    task automatic tx_write(input logic [7:0] b);
        @(negedge clk);
        u_if0.TX_DV   = 1'b1;
        u_if0.TX_Byte = b;
        @(negedge clk);
        u_if0.TX_DV   = 1'b0;
    endtask

    task automatic chk_reset(input string tag, input logic dv, input logic [7:0] byt,
                             input logic rdy, input logic ovr, input logic mi,
                             input logic en);
        check({tag, "_rx_dv"},    {31'd0, dv},  32'd0);
        check({tag, "_rx_byte"},  {24'd0, byt}, 32'd0);
        check({tag, "_tx_ready"}, {31'd0, rdy}, 32'd1);
        check({tag, "_overrun"},  {31'd0, ovr}, 32'd0);
        check({tag, "_miso"},     {31'd0, mi},  32'd1);
        check({tag, "_miso_en"},  {31'd0, en},  32'd0);
    endtask

    logic [7:0] junk;

    initial begin
        rst     = 1'b1;
        spi_clk = 3'b001;
        cs_n    = 3'b111;
        mosi    = 3'b000;
        u_if0.TX_DV = 1'b0; u_if0.TX_Byte = 8'h00;
        u_if1.TX_DV = 1'b0; u_if1.TX_Byte = 8'h00;
        u_if2.TX_DV = 1'b0; u_if2.TX_Byte = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset("rst0", u_if0.RX_DV, u_if0.RX_Byte, u_if0.TX_Ready, u_if0.Overrun,
                  miso[0], miso_en[0]);
        chk_reset("rst1", u_if1.RX_DV, u_if1.RX_Byte, u_if1.TX_Ready, u_if1.Overrun,
                  miso[1], miso_en[1]);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 3, default reply.
        spi_begin(0);
        check("t1_miso_en", {31'd0, miso_en[0]}, 32'd1);
        xfer_byte(0, 8'h55, 8'hFF, "t1_miso");
        spi_end(0);
        check("t1_miso_en_idle", {31'd0, miso_en[0]}, 32'd0);

        // Loaded reply byte.
        tx_write(8'hA3);
        check("t2_ready_after_wr", {31'd0, u_if0.TX_Ready}, 32'd0);
        spi_begin(0);
        check("t2_ready_after_load", {31'd0, u_if0.TX_Ready}, 32'd1);
        xfer_byte(0, 8'h3C, 8'hA3, "t2_miso");
        spi_end(0);

        // Back-to-back bytes under one CS.
        spi_begin(0);
        xfer_byte(0, 8'h01, 8'hFF, "t3_miso_b0");
        xfer_byte(0, 8'h80, 8'hFF, "t3_miso_b1");
        xfer_byte(0, 8'hFF, 8'hFF, "t3_miso_b2");
        spi_end(0);

        // Aborted partial byte, then a full one.
        spi_begin(0);
        spi_bits(0, 8'hE7, 5, junk);
        spi_end(0);
        check("t4_miso_idle", {31'd0, miso[0]}, 32'd1);
        check("t4_miso_en_idle", {31'd0, miso_en[0]}, 32'd0);
        spi_begin(0);
        xfer_byte(0, 8'hC6, 8'hFF, "t4_miso");
        spi_end(0);

        // Overrun: second write ignored, sticky flag.
        tx_write(8'h11);
        tx_write(8'h22);
        check("t5_overrun_set", {31'd0, u_if0.Overrun}, 32'd1);
        spi_begin(0);
        xfer_byte(0, 8'h5A, 8'h11, "t5_miso_held");
        spi_end(0);
        spi_begin(0);
        xfer_byte(0, 8'hA5, 8'hFF, "t5_miso_next");
        spi_end(0);
        check("t5_overrun_sticky", {31'd0, u_if0.Overrun}, 32'd1);

        // Reset mid-byte.
        spi_begin(0);
        spi_bits(0, 8'hF0, 4, junk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("t6_rst", u_if0.RX_DV, u_if0.RX_Byte, u_if0.TX_Ready, u_if0.Overrun,
                  miso[0], miso_en[0]);
        rst = 1'b0;
        spi_end(0);

        spi_begin(1);
        xfer_byte(1, 8'h55, 8'hFF, "t6_mode0_miso");
        spi_end(1);
        spi_begin(2);
        xfer_byte(2, 8'h55, 8'hFF, "t6_mode1_miso");
        spi_end(2);

        repeat (20) @(negedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        check("q2_drained", q2.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
